// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use interlock,
// MDU and data-memory wait states, branch flushes, timeout flag and stall counter.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_addrD,
  input  logic [4:0]       rs2_addrD,
  input  logic [4:0]       rd_addrE,
  input  logic             rd_wrenE,
  input  logic             wb_selE,
  input  logic             br_selE,
  input  logic             mdu_startE,
  input  logic             mdu_done,
  input  logic             lsu_reqM,
  input  logic             lsu_ack,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             mdu_start_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic              r_mem_err, w_set_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu, w_eval;
  logic              w_stallF, w_stallD, w_stallE, w_stallM;
  logic              w_flushD, w_flushE, w_flushM, w_flushW, w_mdu_start;

  assign w_lu = wb_selE & rd_wrenE & (rd_addrE != 5'd0) &
                ((rd_addrE == rs1_addrD) | (rd_addrE == rs2_addrD));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_err      = 1'b0;
    w_eval         = 1'b0;
    w_stallF       = 1'b0;
    w_stallD       = 1'b0;
    w_stallE       = 1'b0;
    w_stallM       = 1'b0;
    w_flushD       = 1'b0;
    w_flushE       = 1'b0;
    w_flushM       = 1'b0;
    w_flushW       = 1'b0;
    w_mdu_start    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (lsu_reqM & ~lsu_ack) begin
          {w_stallF, w_stallD, w_stallE, w_stallM, w_flushW} = '1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end else begin
          w_eval = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (!mdu_done) begin
          {w_stallF, w_stallD, w_stallE, w_flushM} = '1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        // An ack releases MEM and lets the held EX/ID work be acted on in the same cycle.
        if (lsu_ack) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
          w_eval         = 1'b1;
        end else begin
          {w_stallF, w_stallD, w_stallE, w_stallM, w_flushW} = '1;
          if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            w_set_err      = 1'b1;
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_eval) begin
      if (mdu_startE) begin
        w_mdu_start = 1'b1;
        {w_stallF, w_stallD, w_stallE, w_flushM} = '1;
        w_state_nxt = MDU_WAIT;
      end else if (br_selE) begin
        {w_flushD, w_flushE} = '1;
      end else if (w_lu) begin
        {w_stallF, w_stallD, w_flushE} = '1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_err) r_mem_err <= 1'b1;
      if (w_stallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stallF      = w_stallF & rst_ni;
  assign stallD      = w_stallD & rst_ni;
  assign stallE      = w_stallE & rst_ni;
  assign stallM      = w_stallM & rst_ni;
  assign flushD      = w_flushD & rst_ni;
  assign flushE      = w_flushE & rst_ni;
  assign flushM      = w_flushM & rst_ni;
  assign flushW      = w_flushW & rst_ni;
  assign mdu_start_o = w_mdu_start & rst_ni;
  assign mem_err_o   = r_mem_err;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle vector table plus hand-written
// timeout, counter-saturation and asynchronous-reset sequences.
module tb_pipeline_ctrl;

  localparam logic [7:0] F_NONE = 8'b0000_0000;
  localparam logic [7:0] F_LU   = 8'b1100_0100;  // {sF,sD,sE,sM,fD,fE,fM,fW}
  localparam logic [7:0] F_MDU  = 8'b1110_0010;
  localparam logic [7:0] F_MEM  = 8'b1111_0001;
  localparam logic [7:0] F_BR   = 8'b0000_1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       wren, wbsel, br, mst, mdone, req, ack;
  logic       sF, sD, sE, sM, fD, fE, fM, fW, start_o, err_o;
  logic [3:0] cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_addrD(rs1), .rs2_addrD(rs2), .rd_addrE(rd),
    .rd_wrenE(wren), .wb_selE(wbsel), .br_selE(br),
    .mdu_startE(mst), .mdu_done(mdone),
    .lsu_reqM(req), .lsu_ack(ack),
    .stallF(sF), .stallD(sD), .stallE(sE), .stallM(sM),
    .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW),
    .mdu_start_o(start_o), .mem_err_o(err_o), .stall_cnt_o(cnt_o)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       wren, wbsel, br, mst, mdone, req, ack;
    logic [7:0] ef;
    logic       es;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] a1, a2, d,
                              input logic w, l, b, m, dn, rq, ak,
                              input logic [7:0] ef, input logic es, input logic [3:0] ec);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.rd = d; v.wren = w; v.wbsel = l; v.br = b;
    v.mst = m; v.mdone = dn; v.req = rq; v.ack = ak; v.ef = ef; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, a2, d, input logic w, l, b, m, dn, rq, ak);
    rs1 = a1; rs2 = a2; rd = d; wren = w; wbsel = l; br = b;
    mst = m; mdone = dn; req = rq; ack = ak;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all(input string nm, input logic [7:0] ef, input logic es,
                           input logic ee, input logic [3:0] ec);
    chk({nm, "_flags"}, {23'd0, sF, sD, sE, sM, fD, fE, fM, fW, start_o}, {23'd0, ef, es});
    chk({nm, "_err"}, {31'd0, err_o}, {31'd0, ee});
    chk({nm, "_cnt"}, {28'd0, cnt_o}, {28'd0, ec});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #12;
    check_all("reset", F_NONE, 1'b0, 1'b0, 4'd0);
    idle();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // rs1, rs2, rd, wren, wb, br, mst, mdone, req, ack, flags, start, cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 0));
    vecs.push_back(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, F_LU,   0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, F_NONE, 0, 1));
    vecs.push_back(mk(7, 3, 7, 1, 1, 0, 0, 0, 0, 0, F_LU,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 2));
    vecs.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, F_NONE, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, F_BR,   0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, F_MDU,  1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, F_MDU,  0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, F_MDU,  0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, F_MDU,  0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, F_NONE, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_NONE, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, F_MEM,  0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, F_MEM,  0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, F_MEM,  0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, F_BR,   0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, F_NONE, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, F_MEM,  0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, F_MDU,  1, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, F_NONE, 0, 11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 11));
    vecs.push_back(mk(9, 2, 9, 1, 1, 0, 0, 0, 1, 0, F_MEM,  0, 11));
    vecs.push_back(mk(9, 2, 9, 1, 1, 0, 0, 0, 1, 1, F_LU,   0, 12));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 13));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, F_MDU,  1, 13));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, F_NONE, 0, 14));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 14));

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wren, vecs[i].wbsel,
            vecs[i].br, vecs[i].mst, vecs[i].mdone, vecs[i].req, vecs[i].ack);
      #3;
      check_all($sformatf("v%0d", i), vecs[i].ef, vecs[i].es, 1'b0, vecs[i].ec);
      step();
    end

    // Memory timeout: 8 stalled cycles, then release with the error latched.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      check_all($sformatf("tmo%0d", i), F_MEM, 1'b0, 1'b0, 4'(i));
      step();
    end
    idle();
    #3;
    check_all("tmo_rel", F_NONE, 1'b0, 1'b1, 4'd8);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      check_all($sformatf("fresh%0d", i), F_MEM, 1'b0, 1'b1, 4'(8 + i));
      step();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    check_all("fresh_ack", F_NONE, 1'b0, 1'b1, 4'd10);
    step();

    // Held load-use stalls every cycle; counter must stop at 15.
    for (int i = 0; i < 7; i++) begin
      drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      check_all($sformatf("sat%0d", i), F_LU, 1'b0, 1'b1, ((10 + i) > 15) ? 4'd15 : 4'(10 + i));
      step();
    end
    idle();
    #3;
    check_all("sat_end", F_NONE, 1'b0, 1'b1, 4'd15);
    step();

    // Asynchronous reset in the middle of an MDU wait.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check_all("rm_start", F_MDU, 1'b1, 1'b1, 4'd15);
    step();
    #3;
    check_all("rm_wait", F_MDU, 1'b0, 1'b1, 4'd15);
    rst_n = 1'b0;
    #1;
    check_all("rm_async", F_NONE, 1'b0, 1'b0, 4'd0);
    step();
    check_all("rm_held", F_NONE, 1'b0, 1'b0, 4'd0);
    idle();
    rst_n = 1'b1;
    #3;
    check_all("rm_rel", F_NONE, 1'b0, 1'b0, 4'd0);
    step();
    #3;
    check_all("rm_run", F_NONE, 1'b0, 1'b0, 4'd0);
    step();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check_all("rm_newop", F_MDU, 1'b1, 1'b0, 4'd0);
    step();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    check_all("rm_done", F_NONE, 1'b0, 1'b0, 4'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the forwarding hazard logic and owns every stage-register enable and bubble insertion. It covers four cases: the load-use interlock, multi-cycle MDU operations in EX, data-memory wait states in MEM, and branch-redirect flushes. It also provides a memory-timeout error flag and a stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 64: cycles a MEM access may wait for `lsu_ack` before abort; must be ≥ 2.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- rs1_addrD, rs2_addrD  in  5  source registers of the instruction in ID
- rd_addrE  in  5  destination register of the instruction in EX
- rd_wrenE  in  1  EX instruction writes rd
- wb_selE  in  1  EX instruction is a load
- br_selE  in  1  EX resolved a taken branch/jump
- mdu_startE  in  1  EX holds a multi-cycle MUL/DIV op
- mdu_done  in  1  MDU result valid this cycle
- lsu_reqM  in  1  MEM holds a load/store
- lsu_ack  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers
- flushD, flushE, flushM, flushW  out  1  load a bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
- mdu_start_o  out  1  one-cycle start pulse to the MDU
- mem_err_o  out  1  sticky memory-timeout flag
- stall_cnt_o  out  CNT_W  saturating count of cycles with stallF=1

## Operation
- FSM states: RUN, MDU_WAIT, MEM_WAIT. The encoding is free.
- Reset values: state RUN, wait counter 0, mem_err_o 0, stall_cnt_o 0. While rst_ni=0, all stall/flush outputs and mdu_start_o are forced to 0.
- Load-use hazard (`lu`): wb_selE & rd_wrenE & (rd_addrE≠0) & (rd_addrE==rs1_addrD | rd_addrE==rs2_addrD).
- RUN evaluates conditions in strict priority order; only the first true one acts:
  1. lsu_reqM & ~lsu_ack: stallF/D/E/M=1, flushW=1; next state MEM_WAIT; wait counter ← 1.
  2. mdu_startE: mdu_start_o=1, stallF/D/E=1, flushM=1; next state MDU_WAIT.
  3. br_selE: flushD=1, flushE=1, no stalls.
  4. lu: stallF/D=1, flushE=1 for this single cycle. The cycle after, lu is false and the pipeline proceeds.
  5. Otherwise all outputs are 0.
- MDU_WAIT:
  - While mdu_done=0: stallF/D/E=1, flushM=1, mdu_start_o=0.
  - On mdu_done=1: all stalls released, flushM=0, next state RUN. The EX result advances into EX-MEM on that edge.
- MEM_WAIT:
  - stallF/D/E/M=1 and flushW=1 each cycle; the wait counter increments.
  - On lsu_ack=1: release everything that cycle, next state RUN, counter ← 0.
  - If the counter reaches MEM_TIMEOUT with no ack: set mem_err_o=1, release as if acked (the access is abandoned), next state RUN.
  - mem_err_o stays 1 until reset.
- Because MEM priority is higher, a branch or MDU op in EX is held, not acted on, while MEM waits. It is re-evaluated once MEM releases. mdu_start_o therefore never fires during a MEM stall.
- An mdu_done arriving in RUN or MEM_WAIT is ignored.
- stall_cnt_o increments on every cycle with stallF=1 and saturates at all-ones (no wrap).

## Timing
- All stall/flush outputs and mdu_start_o are combinational from state and inputs, with zero-cycle latency to the stage-register enables.
- Load-use costs exactly 1 bubble. A taken branch costs exactly 2 flushed slots.
- An MDU op with done N cycles after start stalls EX for N cycles (start cycle through the cycle before done). mdu_start_o is high exactly one cycle per op.
- A memory access acked K cycles after first request stalls for K cycles.
- The timeout fires on the MEM_TIMEOUT-th stalled cycle. mem_err_o becomes visible the next cycle.
- Async reset mid-MDU_WAIT or mid-MEM_WAIT returns to RUN immediately: outputs 0, counters cleared. No pulse is issued on reset release.

## Test plan
- Load x5 in EX, ID reads rs2=x5: one cycle of stallF=stallD=flushE=1. Next cycle all 0. stall_cnt_o=1.
- Same as above with rd_addrE=0: no stall or flush.
- mdu_startE with mdu_done 4 cycles later:
  - mdu_start_o high 1 cycle.
  - stallE=flushM=1 for 4 cycles.
  - RUN on the done cycle.
  - stall_cnt_o=4.
- lsu_reqM with lsu_ack after 3 cycles while br_selE=1 in EX:
  - stallF–M=1 and flushW=1 for 3 cycles, with no flushD.
  - On the release cycle, flushD=flushE=1.
- MEM_TIMEOUT=8, lsu_ack never asserted:
  - release after 8 stalled cycles, mem_err_o=1 thereafter.
  - a fresh access still works, and mem_err_o stays 1.
- Drop rst_ni during MDU_WAIT: stalls drop to 0 immediately. After release, the FSM is in RUN with stall_cnt_o=0 and mem_err_o=0.
